// File: rtl/output_switch_guarded_if.sv
// Signal bundle between the two CPU output buses, the select line and the
// guarded pin switch.
//   ctr_io         : owner select (0 = CPU A, 1 = CPU B), asynchronous to clk
//   output_from_A  : CPU A pin values
//   output_from_B  : CPU B pin values
//   output_pin     : registered pin bank
//   active_sel     : current owner, meaningful while switching = 0
//   switching      : high while the pins are held in the guard interval
//   switch_cnt     : saturating count of completed owner changes
// master = the surrounding system, slave = output_switch_guarded.
interface output_switch_guarded_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ctr_io;
  logic [WIDTH-1:0] output_from_A;
  logic [WIDTH-1:0] output_from_B;
  logic [WIDTH-1:0] output_pin;
  logic             active_sel;
  logic             switching;
  logic [7:0]       switch_cnt;

  modport master (
    output ctr_io,
    output output_from_A,
    output output_from_B,
    input  output_pin,
    input  active_sel,
    input  switching,
    input  switch_cnt
  );

  modport slave (
    input  ctr_io,
    input  output_from_A,
    input  output_from_B,
    output output_pin,
    output active_sel,
    output switching,
    output switch_cnt
  );
endinterface

// File: rtl/output_switch_guarded.sv
// Dual-CPU output pin switch with a guard interval.
// The pin bank is driven from CPU A or CPU B depending on the synchronised
// ctr_io line. Every change of owner passes through GUARD, where the pins
// hold SAFE_VALUE for GUARD_CYCLES edges, so the two sources never mix.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of output_switch_guarded_if (select, sources,
//            pins, owner/guard status, switch counter)
module output_switch_guarded #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      GUARD_CYCLES = 4,
  parameter logic [WIDTH-1:0] SAFE_VALUE   = '1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output_switch_guarded_if.slave  bus
);

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    OWN_A = 2'd0,
    OWN_B = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic             w_ctr_s;
  logic [7:0]       r_gcnt, w_gcnt_nxt;
  logic [WIDTH-1:0] r_pin, w_pin_nxt;
  logic             r_active, w_active_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_boot, w_boot_nxt;

  // Select synchroniser; the last stage is the only one the FSM looks at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ctr_io};
    end
  end

  assign w_ctr_s = r_sync[SYNC_STAGES-1];

  // r_active only changes on guard exit, so during GUARD it still holds the
  // pre-guard owner and doubles as the reference for counting real changes.
  // r_boot marks the guard that follows reset, whose exit is never counted.
  always_comb begin
    w_state_nxt  = r_state;
    w_gcnt_nxt   = r_gcnt;
    w_active_nxt = r_active;
    w_cnt_nxt    = r_cnt;
    w_boot_nxt   = r_boot;
    case (r_state)
      OWN_A: begin
        if (w_ctr_s) begin
          w_state_nxt = GUARD;
          w_gcnt_nxt  = GUARD_LOAD;
        end
      end
      OWN_B: begin
        if (!w_ctr_s) begin
          w_state_nxt = GUARD;
          w_gcnt_nxt  = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (r_gcnt != 8'd0) begin
          w_gcnt_nxt = r_gcnt - 8'd1;
        end else begin
          w_state_nxt  = w_ctr_s ? OWN_B : OWN_A;
          w_active_nxt = w_ctr_s;
          w_boot_nxt   = 1'b0;
          if (!r_boot && (w_ctr_s != r_active) && (r_cnt != 8'hFF)) begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = GUARD;
        w_gcnt_nxt  = GUARD_LOAD;
      end
    endcase
  end

  // Pin value follows the state being entered, not the current one, so the
  // first guard edge already drives SAFE_VALUE.
  always_comb begin
    w_pin_nxt = SAFE_VALUE;
    case (w_state_nxt)
      OWN_A:   w_pin_nxt = bus.output_from_A;
      OWN_B:   w_pin_nxt = bus.output_from_B;
      default: w_pin_nxt = SAFE_VALUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= GUARD;
      r_gcnt   <= GUARD_LOAD;
      r_pin    <= SAFE_VALUE;
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_boot   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_pin    <= w_pin_nxt;
      r_active <= w_active_nxt;
      r_cnt    <= w_cnt_nxt;
      r_boot   <= w_boot_nxt;
    end
  end

  assign bus.output_pin = r_pin;
  assign bus.active_sel = r_active;
  assign bus.switching  = (r_state == GUARD);
  assign bus.switch_cnt = r_cnt;

endmodule

// File: tb/tb_output_switch_guarded.sv
module tb_output_switch_guarded;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  output_switch_guarded_if #(.WIDTH(8))  if0 ();
  output_switch_guarded_if #(.WIDTH(16)) if1 ();

  output_switch_guarded u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  output_switch_guarded #(
    .WIDTH        (16),
    .SYNC_STAGES  (3),
    .GUARD_CYCLES (1),
    .SAFE_VALUE   (16'h0000)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n consecutive edges, each followed by a pin check on the default DUT
  task automatic pins0(input string tag, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, 32'(if0.output_pin), 32'(v));
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    if0.ctr_io        = 1'b0;
    if0.output_from_A = 8'h5A;
    if0.output_from_B = 8'hC3;
    if1.ctr_io        = 1'b0;
    if1.output_from_A = 16'h1234;
    if1.output_from_B = 16'hABCD;
    #12;
    chk("rst_pin",    32'(if0.output_pin), 32'hFF);
    chk("rst_sw",     32'(if0.switching),  32'd1);
    chk("rst_act",    32'(if0.active_sel), 32'd0);
    chk("rst_cnt",    32'(if0.switch_cnt), 32'd0);
    chk("rst_pin16",  32'(if1.output_pin), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // post-reset guard
    tick();
    chk("boot_pin_e1", 32'(if0.output_pin), 32'hFF);
    chk("boot16_own_a", 32'(if1.output_pin), 32'h1234);
    pins0("boot_guard", 2, 8'hFF);
    chk("boot_sw", 32'(if0.switching), 32'd1);
    tick();
    chk("boot_own_a", 32'(if0.output_pin), 32'h5A);
    chk("boot_sw_low", 32'(if0.switching), 32'd0);
    chk("boot_act", 32'(if0.active_sel), 32'd0);
    chk("boot_cnt", 32'(if0.switch_cnt), 32'd0);

    if0.output_from_A = 8'h11;
    tick();
    chk("follow_a", 32'(if0.output_pin), 32'h11);

    // A -> B
    if0.ctr_io = 1'b1;
    pins0("ab_pre", 2, 8'h11);
    pins0("ab_guard", 4, 8'hFF);
    chk("ab_sw", 32'(if0.switching), 32'd1);
    tick();
    chk("ab_pin", 32'(if0.output_pin), 32'hC3);
    chk("ab_act", 32'(if0.active_sel), 32'd1);
    chk("ab_cnt", 32'(if0.switch_cnt), 32'd1);
    chk("ab_sw_low", 32'(if0.switching), 32'd0);

    // B -> guard -> B glitch
    if0.ctr_io = 1'b0;
    pins0("bg_pre", 2, 8'hC3);
    pins0("bg_entry", 1, 8'hFF);
    if0.ctr_io = 1'b1;
    pins0("bg_guard", 3, 8'hFF);
    tick();
    chk("bg_pin", 32'(if0.output_pin), 32'hC3);
    chk("bg_cnt", 32'(if0.switch_cnt), 32'd1);
    chk("bg_act", 32'(if0.active_sel), 32'd1);

    // B -> A
    if0.ctr_io = 1'b0;
    pins0("ba_pre", 2, 8'hC3);
    pins0("ba_guard", 4, 8'hFF);
    tick();
    chk("ba_pin", 32'(if0.output_pin), 32'h11);
    chk("ba_cnt", 32'(if0.switch_cnt), 32'd2);
    chk("ba_act", 32'(if0.active_sel), 32'd0);

    // A -> guard -> A glitch
    if0.ctr_io = 1'b1;
    pins0("ag_pre", 2, 8'h11);
    pins0("ag_entry", 1, 8'hFF);
    if0.ctr_io = 1'b0;
    pins0("ag_guard", 3, 8'hFF);
    tick();
    chk("ag_pin", 32'(if0.output_pin), 32'h11);
    chk("ag_cnt", 32'(if0.switch_cnt), 32'd2);

    // reset in the middle of a guard
    if0.ctr_io = 1'b1;
    pins0("mr_pre", 2, 8'h11);
    pins0("mr_guard", 2, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_pin", 32'(if0.output_pin), 32'hFF);
    chk("mr_cnt", 32'(if0.switch_cnt), 32'd0);
    chk("mr_sw",  32'(if0.switching),  32'd1);
    chk("mr_act", 32'(if0.active_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pins0("mr_boot_guard", 3, 8'hFF);
    tick();
    chk("mr_own_b", 32'(if0.output_pin), 32'hC3);
    chk("mr_act_b", 32'(if0.active_sel), 32'd1);
    chk("mr_cnt_b", 32'(if0.switch_cnt), 32'd0);

    // saturation: 300 real owner changes
    for (int i = 1; i <= 300; i++) begin
      if0.ctr_io = ~if0.ctr_io;
      repeat (8) tick();
      if (i == 254) chk("sat_254", 32'(if0.switch_cnt), 32'd254);
      if (i == 255) chk("sat_255", 32'(if0.switch_cnt), 32'd255);
    end
    chk("sat_final", 32'(if0.switch_cnt), 32'd255);
    chk("sat_pin",   32'(if0.output_pin), 32'hC3);
    chk("sat_act",   32'(if0.active_sel), 32'd1);

    // WIDTH=16, SYNC_STAGES=3, GUARD_CYCLES=1, SAFE_VALUE=0
    if1.ctr_io = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w16_pre", 32'(if1.output_pin), 32'h1234);
    end
    tick();
    chk("w16_guard", 32'(if1.output_pin), 32'h0000);
    chk("w16_sw",    32'(if1.switching),  32'd1);
    tick();
    chk("w16_pin_b", 32'(if1.output_pin), 32'hABCD);
    chk("w16_sw_low", 32'(if1.switching), 32'd0);
    chk("w16_act",   32'(if1.active_sel), 32'd1);
    chk("w16_cnt",   32'(if1.switch_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
